dcm_reset_ctrl: RTL and testbench

- Sequences the DCM_SP clock generator that produces the 100 MHz and 25 MHz clocks.
- Drives the DCM's active-high RST with a minimum-width pulse, then waits for LOCKED.
- Qualifies lock for a stabilisation window, then releases the system reset.
- Monitors lock and CLKFX-stopped status; on loss it re-sequences, and after repeated failures it latches a fault.
- Runs on the free-running board input clock, never on a DCM output.

---
 rtl/dcm_ctrl_pkg.sv | 43 ++++
 rtl/dcm_reset_ctrl_sync.sv | 28 ++
 rtl/dcm_reset_ctrl.sv | 158 +++++++++++++++
 tb/tb_dcm_reset_ctrl.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dcm_ctrl_pkg.sv
// Shared definitions for the DCM reset controller: state encodings,
// default parameter values, DCM STATUS bit positions and sizing helpers.
package dcm_ctrl_pkg;

  // Default parameter values
  localparam int unsigned DEF_RST_CYCLES    = 4;
  localparam int unsigned DEF_LOCK_TIMEOUT  = 65536;
  localparam int unsigned DEF_STABLE_CYCLES = 1024;
  localparam int unsigned DEF_MAX_RETRY     = 7;

  // DCM STATUS bit positions
  localparam int unsigned CLKIN_STOP = 1;
  localparam int unsigned CLKFX_STOP = 2;

  // Port widths
  localparam int unsigned STATUS_W = 8;
  localparam int unsigned RETRY_W  = 4;
  localparam int unsigned STATE_W  = 3;

  // Controller states; the encodings are visible on the debug STATE port
  typedef enum logic [STATE_W-1:0] {
    ST_RST_DCM   = 3'd0,
    ST_WAIT_LOCK = 3'd1,
    ST_STABILIZE = 3'd2,
    ST_RUN       = 3'd3,
    ST_FAULT     = 3'd4
  } dcm_state_e;

  // Largest of three values, used to size the shared phase counter
  function automatic int unsigned max3(input int unsigned a,
                                       input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

  // Counter width able to hold 0..n-1, never narrower than one bit
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/dcm_reset_ctrl_sync.sv
// Two-flop synchroniser bank for asynchronous level inputs.
//   clk   : destination clock
//   rst_n : asynchronous active-low reset, clears both stages
//   d     : asynchronous inputs
//   q     : synchronised outputs, two clk cycles behind d
module sync_2ff #(
  parameter int unsigned WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  // First stage may go metastable; second stage gives it a cycle to settle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/dcm_reset_ctrl.sv
// DCM_SP bring-up and supervision. Pulses the DCM RST, waits for LOCKED,
// qualifies lock for a stabilisation window, then releases the system reset.
// Loss of lock or a stopped CLKFX re-sequences the DCM; repeated failures
// latch FAULT until RESTART or RESET_N. Clocked only by the board clock.
//   CLK_IN1    : free-running board clock (also feeds DCM CLKIN)
//   RESET_N    : asynchronous active-low reset
//   DCM_LOCKED : DCM LOCKED, asynchronous
//   DCM_STATUS : DCM STATUS, asynchronous; bit1 CLKIN stopped, bit2 CLKFX stopped
//   RESTART    : single-cycle restart request, honoured in RUN and FAULT
//   DCM_RST    : DCM RST, active high
//   SYS_RST    : active-high reset for the DCM-clocked logic
//   CLK_OK     : high only in RUN
//   FAULT      : high only in FAULT
//   RETRY_CNT  : failed attempts since RESET_N or RESTART
//   STATE      : current state encoding, for debug
module dcm_reset_ctrl
  import dcm_ctrl_pkg::*;
#(
  parameter int unsigned RST_CYCLES    = DEF_RST_CYCLES,
  parameter int unsigned LOCK_TIMEOUT  = DEF_LOCK_TIMEOUT,
  parameter int unsigned STABLE_CYCLES = DEF_STABLE_CYCLES,
  parameter int unsigned MAX_RETRY     = DEF_MAX_RETRY
) (
  input  logic                CLK_IN1,
  input  logic                RESET_N,
  input  logic                DCM_LOCKED,
  input  logic [STATUS_W-1:0] DCM_STATUS,
  input  logic                RESTART,
  output logic                DCM_RST,
  output logic                SYS_RST,
  output logic                CLK_OK,
  output logic                FAULT,
  output logic [RETRY_W-1:0]  RETRY_CNT,
  output logic [STATE_W-1:0]  STATE
);

  localparam int unsigned CNT_MAX = max3(RST_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES);
  localparam int unsigned CW      = cnt_width(CNT_MAX);

  localparam logic [CW-1:0]      RST_LAST     = CW'(RST_CYCLES - 1);
  localparam logic [CW-1:0]      TIMEOUT_LAST = CW'(LOCK_TIMEOUT - 1);
  localparam logic [CW-1:0]      STABLE_LAST  = CW'(STABLE_CYCLES - 1);
  localparam logic [RETRY_W:0]   RETRY_LIMIT  = (RETRY_W+1)'(MAX_RETRY);
  localparam logic [RETRY_W-1:0] RETRY_FAULT  = RETRY_W'(MAX_RETRY);
  localparam logic [RETRY_W-1:0] RETRY_SAT    = '1;

  dcm_state_e         state, state_nxt;
  logic [CW-1:0]      cnt, cnt_nxt;
  logic [RETRY_W-1:0] retry, retry_nxt;
  logic               dcm_rst_nxt, sys_rst_nxt, clk_ok_nxt, fault_nxt;
  logic               fail_c;
  logic [2:0]         sync_d, sync_q;
  logic               lock_ok_c;
  logic [RETRY_W:0]   retry_sum_c;

  // Status bits the controller does not act on
  logic unused_status;
  assign unused_status = ^{DCM_STATUS[7:3], DCM_STATUS[0]};

  // Bring LOCKED and the two clock-stopped flags into the CLK_IN1 domain
  assign sync_d = {DCM_STATUS[CLKFX_STOP], DCM_STATUS[CLKIN_STOP], DCM_LOCKED};

  sync_2ff #(.WIDTH(3)) u_sync (
    .clk   (CLK_IN1),
    .rst_n (RESET_N),
    .d     (sync_d),
    .q     (sync_q)
  );

  // Lock is only trusted while both input and synthesised clocks are running
  assign lock_ok_c   = sync_q[0] & ~sync_q[1] & ~sync_q[2];
  assign retry_sum_c = {1'b0, retry} + (RETRY_W+1)'(1);

  // State, counter, retry count and registered outputs
  always_ff @(posedge CLK_IN1 or negedge RESET_N) begin
    if (!RESET_N) begin
      state   <= ST_RST_DCM;
      cnt     <= '0;
      retry   <= '0;
      DCM_RST <= 1'b1;
      SYS_RST <= 1'b1;
      CLK_OK  <= 1'b0;
      FAULT   <= 1'b0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      retry   <= retry_nxt;
      DCM_RST <= dcm_rst_nxt;
      SYS_RST <= sys_rst_nxt;
      CLK_OK  <= clk_ok_nxt;
      FAULT   <= fault_nxt;
    end
  end

  // Next-state, counter and retry logic; outputs follow the next state
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt + CW'(1);
    retry_nxt = retry;
    fail_c    = 1'b0;

    case (state)
      ST_RST_DCM: begin
        if (cnt == RST_LAST) state_nxt = ST_WAIT_LOCK;
      end
      ST_WAIT_LOCK: begin
        if (lock_ok_c)                state_nxt = ST_STABILIZE;
        else if (cnt == TIMEOUT_LAST) fail_c    = 1'b1;
      end
      ST_STABILIZE: begin
        if (!lock_ok_c)              fail_c    = 1'b1;
        else if (cnt == STABLE_LAST) state_nxt = ST_RUN;
      end
      ST_RUN: begin
        cnt_nxt = cnt;
        // A restart wins over a simultaneous lock loss, so no retry is counted
        if (RESTART) begin
          state_nxt = ST_RST_DCM;
          retry_nxt = '0;
        end else if (!lock_ok_c) begin
          fail_c = 1'b1;
        end
      end
      ST_FAULT: begin
        cnt_nxt = cnt;
        if (RESTART) begin
          state_nxt = ST_RST_DCM;
          retry_nxt = '0;
        end
      end
      default: begin
        state_nxt = ST_FAULT;
      end
    endcase

    if (fail_c) begin
      if (retry_sum_c >= RETRY_LIMIT) begin
        state_nxt = ST_FAULT;
        retry_nxt = RETRY_FAULT;
      end else begin
        state_nxt = ST_RST_DCM;
        retry_nxt = (retry == RETRY_SAT) ? RETRY_SAT : retry + RETRY_W'(1);
      end
    end

    // Each state times itself from zero
    if (state_nxt != state) cnt_nxt = '0;

    dcm_rst_nxt = (state_nxt == ST_RST_DCM) || (state_nxt == ST_FAULT);
    sys_rst_nxt = (state_nxt != ST_RUN);
    clk_ok_nxt  = (state_nxt == ST_RUN);
    fault_nxt   = (state_nxt == ST_FAULT);
  end

  assign RETRY_CNT = retry;
  assign STATE     = state;

endmodule

// File: tb/tb_dcm_reset_ctrl.sv
// Directed bench for dcm_reset_ctrl: a phase/countdown model of the
// controller is checked against the DUT every cycle, and hand-computed
// latencies and values pin the model at each scenario.
module tb_dcm_reset_ctrl;

  localparam int P_RST  = 4;
  localparam int P_TO   = 32;
  localparam int P_STAB = 16;
  localparam int P_MAX  = 3;

  localparam int PH_RST = 0, PH_WAIT = 1, PH_STAB = 2, PH_RUN = 3, PH_FAULT = 4;
  localparam int W_DCM = 0, W_SYS = 1, W_CLKOK = 2, W_FAULT = 3, W_STATE = 4;

  logic       clk, rst_n, locked, restart;
  logic [7:0] status;
  logic       dcm_rst, sys_rst, clk_ok, fault;
  logic [3:0] retry;
  logic [2:0] state;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  dcm_reset_ctrl #(
    .RST_CYCLES    (P_RST),
    .LOCK_TIMEOUT  (P_TO),
    .STABLE_CYCLES (P_STAB),
    .MAX_RETRY     (P_MAX)
  ) dut (
    .CLK_IN1    (clk),
    .RESET_N    (rst_n),
    .DCM_LOCKED (locked),
    .DCM_STATUS (status),
    .RESTART    (restart),
    .DCM_RST    (dcm_rst),
    .SYS_RST    (sys_rst),
    .CLK_OK     (clk_ok),
    .FAULT      (fault),
    .RETRY_CNT  (retry),
    .STATE      (state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    vectors = vectors + 1;
    if (act != exp) begin
      miscompares = miscompares + 1;
      $display("FAIL %s @cyc %0d: got %0d, required %0d", name, cyc, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Phase plus cycles-left countdown; lock seen through a two-sample delay.
  int   m_phase, m_left, m_retry;
  int   n_phase, n_left, n_retry;
  logic d1, d2, m_fail;

  always_comb begin
    n_phase = m_phase;
    n_left  = m_left;
    n_retry = m_retry;
    m_fail  = 1'b0;
    case (m_phase)
      PH_RST:   if (m_left == 1) begin n_phase = PH_WAIT; n_left = P_TO; end
                else n_left = m_left - 1;
      PH_WAIT:  if (d2) begin n_phase = PH_STAB; n_left = P_STAB; end
                else if (m_left == 1) m_fail = 1'b1;
                else n_left = m_left - 1;
      PH_STAB:  if (!d2) m_fail = 1'b1;
                else if (m_left == 1) n_phase = PH_RUN;
                else n_left = m_left - 1;
      PH_RUN:   if (restart) begin n_phase = PH_RST; n_left = P_RST; n_retry = 0; end
                else if (!d2) m_fail = 1'b1;
      PH_FAULT: if (restart) begin n_phase = PH_RST; n_left = P_RST; n_retry = 0; end
      default:  ;
    endcase
    if (m_fail) begin
      if (m_retry + 1 >= P_MAX) begin
        n_phase = PH_FAULT;
        n_retry = P_MAX;
      end else begin
        n_phase = PH_RST;
        n_left  = P_RST;
        n_retry = (m_retry + 1 > 15) ? 15 : m_retry + 1;
      end
    end
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_phase <= PH_RST;
      m_left  <= P_RST;
      m_retry <= 0;
      d1      <= 1'b0;
      d2      <= 1'b0;
    end else begin
      m_phase <= n_phase;
      m_left  <= n_left;
      m_retry <= n_retry;
      d2      <= d1;
      d1      <= locked & ~status[1] & ~status[2];
    end
  end

  // Per-cycle comparison, away from the active edge
  always @(negedge clk) begin
    chk("cyc_state",   int'(state),   m_phase);
    chk("cyc_dcm_rst", int'(dcm_rst), int'(m_phase == PH_RST || m_phase == PH_FAULT));
    chk("cyc_sys_rst", int'(sys_rst), int'(m_phase != PH_RUN));
    chk("cyc_clk_ok",  int'(clk_ok),  int'(m_phase == PH_RUN));
    chk("cyc_fault",   int'(fault),   int'(m_phase == PH_FAULT));
    chk("cyc_retry",   int'(retry),   m_retry);
  end

  // Watch for any SYS_RST release while armed
  logic watch_sys = 1'b0;
  logic sys_low_seen = 1'b0;
  always @(negedge clk) if (watch_sys && !sys_rst) sys_low_seen <= 1'b1;

  function automatic int outval(input int w);
    case (w)
      W_DCM:   return int'(dcm_rst);
      W_SYS:   return int'(sys_rst);
      W_CLKOK: return int'(clk_ok);
      W_FAULT: return int'(fault);
      default: return int'(state);
    endcase
  endfunction

  // Wait (bounded) for a DUT output to take a value; at = edge index seen
  task automatic wait_cond(input string name, input int w, input int v,
                           input int budget, output int at);
    at = -1;
    for (int i = 0; i < budget; i++) begin
      @(posedge clk);
      #1;
      if (outval(w) == v) begin
        at = cyc;
        break;
      end
    end
    if (at < 0) begin
      vectors = vectors + 1;
      miscompares = miscompares + 1;
      $display("FAIL %s: no value %0d within %0d cycles, got %0d", name, v, budget, outval(w));
    end
  endtask

  task automatic chk_reset_values(input string tag);
    chk({tag, "_state"},   int'(state),   0);
    chk({tag, "_dcm_rst"}, int'(dcm_rst), 1);
    chk({tag, "_sys_rst"}, int'(sys_rst), 1);
    chk({tag, "_clk_ok"},  int'(clk_ok),  0);
    chk({tag, "_fault"},   int'(fault),   0);
    chk({tag, "_retry"},   int'(retry),   0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int t0, at, r1, r2, f1, ft, s0;
    rst_n   = 1'b0;
    locked  = 1'b0;
    status  = 8'h00;
    restart = 1'b0;
    repeat (3) @(negedge clk);
    chk_reset_values("reset");

    // Lock timeout: three RST pulses 36 cycles apart, then FAULT
    #2 rst_n = 1'b1;
    t0 = cyc;
    wait_cond("dcm_rst_fall0", W_DCM, 0, 10, at);
    chk("dcm_rst_width0", at - t0, 4);
    wait_cond("dcm_rst_rise1", W_DCM, 1, 50, r1);
    chk("retry1_spacing", r1 - t0, 36);
    wait_cond("dcm_rst_fall1", W_DCM, 0, 10, f1);
    chk("dcm_rst_width1", f1 - r1, 4);
    wait_cond("dcm_rst_rise2", W_DCM, 1, 50, r2);
    chk("retry2_spacing", r2 - r1, 36);
    wait_cond("fault_rise", W_FAULT, 1, 50, ft);
    chk("fault_entry", ft - r2, 36);
    chk("fault_retry", int'(retry), 3);
    chk("fault_dcm_rst", int'(dcm_rst), 1);
    chk("fault_state", int'(state), 4);
    repeat (5) @(negedge clk);
    chk("fault_held", int'(fault), 1);

    // RESTART in FAULT
    @(negedge clk) restart = 1'b1;
    @(posedge clk);
    #1;
    chk("restart_state", int'(state), 0);
    chk("restart_fault", int'(fault), 0);
    chk("restart_retry", int'(retry), 0);
    @(negedge clk) restart = 1'b0;

    // Normal bring-up: raw lock sampled next edge, 2 sync edges,
    // the WAIT_LOCK decision edge, then 16 STABILIZE cycles
    repeat (19) @(negedge clk);
    locked = 1'b1;
    t0 = cyc;
    wait_cond("bringup_sys_rst", W_SYS, 0, 40, at);
    chk("bringup_latency", at - t0, 19);
    chk("bringup_clk_ok", int'(clk_ok), 1);
    chk("bringup_retry", int'(retry), 0);

    // One-cycle lock loss in RUN
    repeat (5) @(negedge clk);
    locked = 1'b0;
    t0 = cyc;
    @(negedge clk) locked = 1'b1;
    wait_cond("loss_sys_rst", W_SYS, 1, 8, at);
    chk("loss_latency", at - t0, 3);
    chk("loss_clk_ok", int'(clk_ok), 0);
    chk("loss_retry", int'(retry), 1);
    chk("loss_dcm_rst", int'(dcm_rst), 1);
    wait_cond("loss_dcm_fall", W_DCM, 0, 8, f1);
    chk("loss_dcm_width", f1 - at, 4);
    wait_cond("loss_recover", W_CLKOK, 1, 60, at);
    chk("loss_recover_retry", int'(retry), 1);

    // CLKFX stopped with LOCKED still high
    repeat (5) @(negedge clk);
    status[2] = 1'b1;
    t0 = cyc;
    wait_cond("clkfx_sys_rst", W_SYS, 1, 8, at);
    chk("clkfx_latency", at - t0, 3);
    chk("clkfx_clk_ok", int'(clk_ok), 0);
    chk("clkfx_retry", int'(retry), 2);
    @(negedge clk) status = 8'h00;
    wait_cond("clkfx_recover", W_CLKOK, 1, 60, at);

    // RESTART in RUN clears the retry count
    repeat (3) @(negedge clk);
    restart = 1'b1;
    @(posedge clk);
    #1;
    chk("run_restart_state", int'(state), 0);
    chk("run_restart_retry", int'(retry), 0);
    chk("run_restart_sys_rst", int'(sys_rst), 1);
    @(negedge clk) restart = 1'b0;
    watch_sys = 1'b1;

    // One-cycle glitch at STABILIZE cycle 10
    wait_cond("stab_entry", W_STATE, 2, 20, s0);
    @(negedge clk);
    while (cyc < s0 + 10) @(negedge clk);
    locked = 1'b0;
    @(negedge clk) locked = 1'b1;
    wait_cond("glitch_rst_dcm", W_STATE, 0, 8, at);
    chk("glitch_latency", at - s0, 13);
    chk("glitch_retry", int'(retry), 1);
    chk("glitch_sys_rst", int'(sys_rst), 1);
    chk("glitch_sys_never_low", int'(sys_low_seen), 0);
    watch_sys = 1'b0;

    // Asynchronous reset mid-STABILIZE, checked before the next edge
    wait_cond("stab_entry2", W_STATE, 2, 30, s0);
    repeat (5) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk_reset_values("async");
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b1;
    wait_cond("rerun", W_CLKOK, 1, 60, at);
    chk("rerun_retry", int'(retry), 0);
    repeat (4) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
